// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b memory-interface types and the responder's state encoding.
package lc3b_mem_responder_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Width of the latency down-counter; LATENCY must fit in it.
  localparam int unsigned LC3B_MEM_LAT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } lc3b_mem_state;

endpackage

// File: rtl/lc3b_word_ram.sv
// 16-bit word array with byte-masked synchronous write and a registered read port.
module lc3b_word_ram
  import lc3b_mem_responder_pkg::*;
#(
  parameter int unsigned AddrBits = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [1:0]          be_i,
  input  logic [AddrBits-1:0] index_i,
  input  logic [15:0]         wdata_i,
  output logic [15:0]         rdata_o
);

  lc3b_word mem_q [2**AddrBits];
  lc3b_word rdata_q;

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i[0]) mem_q[index_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[index_i][15:8] <= wdata_i[15:8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[index_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: accepts one read or write, answers with a one-cycle
// mem_resp after LATENCY cycles, backed by lc3b_word_ram.
module lc3b_mem_responder
  import lc3b_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        protocol_err
);

  localparam logic [LC3B_MEM_LAT_W-1:0] LatLoad = LC3B_MEM_LAT_W'(LATENCY - 1);

  lc3b_mem_state               state_q, state_d;
  logic [LC3B_MEM_LAT_W-1:0]   cnt_q, cnt_d;
  logic                        op_write_q, op_write_d;
  logic [ADDR_BITS-1:0]        index_q, index_d;
  lc3b_word                    wdata_q, wdata_d;
  lc3b_mem_wmask               be_q, be_d;
  logic                        perr_q, perr_d;

  logic                        ram_we, ram_re;
  logic [ADDR_BITS-1:0]        ram_index;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^{mem_address[0], mem_address >> (ADDR_BITS + 1)};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    perr_d     = perr_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_index  = index_q;
    unique case (state_q)
      StIdle: begin
        // With LATENCY=1 the read happens on the accept edge, so index the live address.
        ram_index = mem_address[ADDR_BITS:1];
        if (mem_read && mem_write) begin
          perr_d = 1'b1;
        end else if (mem_read || mem_write) begin
          op_write_d = mem_write;
          index_d    = mem_address[ADDR_BITS:1];
          wdata_d    = mem_wdata;
          be_d       = mem_byte_enable;
          cnt_d      = LatLoad;
          if (LatLoad == '0) begin
            state_d = StResp;
            ram_re  = mem_read;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - LC3B_MEM_LAT_W'(1);
        if (cnt_q == LC3B_MEM_LAT_W'(1)) begin
          state_d = StResp;
          ram_re  = !op_write_q;
        end
      end
      StResp: begin
        state_d = StIdle;
        ram_we  = op_write_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      index_q    <= index_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      perr_q     <= perr_d;
    end
  end

  lc3b_word_ram #(
    .AddrBits(ADDR_BITS)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .be_i   (be_q),
    .index_i(ram_index),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    mem_resp     = (state_q == StResp);
    protocol_err = perr_q;
  end

endmodule
